// File: rtl/riscv_dmem_arbiter_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
// Holds the arbiter state encoding, master indices and the byte-select helper.
package riscv_dmem_arbiter_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned DMEM_ADDR_BIT = 14;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_LOCK_M0 = 2'd1,
    ARB_LOCK_M1 = 2'd2
  } arb_state_e;

  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

  // Reads always fetch the full word; writes honour the master's enables.
  function automatic logic [3:0] mem_byte_sel(input logic we, input logic [3:0] byte_sel);
    logic [3:0] sel;
    if (we) begin
      sel = byte_sel;
    end else begin
      sel = 4'hF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/riscv_dmem_arbiter_sel.sv
// Pure two-way winner select: honours lock ownership, otherwise resolves a
// tie towards M1 only when the policy input says so.
module riscv_arb_sel
  import riscv_dmem_arbiter_pkg::*;
(
  input  logic       i_m0_req,
  input  logic       i_m1_req,
  input  arb_state_e i_state,
  input  logic       i_prefer_m1,
  output logic       o_sel_m0,
  output logic       o_sel_m1
);

  // Winner decode from state and requests.
  always_comb begin
    o_sel_m0 = 1'b0;
    o_sel_m1 = 1'b0;
    case (i_state)
      ARB_IDLE: begin
        if (i_m0_req && i_m1_req) begin
          o_sel_m0 = ~i_prefer_m1;
          o_sel_m1 = i_prefer_m1;
        end else begin
          o_sel_m0 = i_m0_req;
          o_sel_m1 = i_m1_req;
        end
      end
      ARB_LOCK_M0: begin
        o_sel_m0 = i_m0_req;
        o_sel_m1 = 1'b0;
      end
      ARB_LOCK_M1: begin
        o_sel_m0 = 1'b0;
        o_sel_m1 = i_m1_req;
      end
      default: begin
        o_sel_m0 = 1'b0;
        o_sel_m1 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Shares the single-port dmem between the CPU port (M0) and an external master (M1).
// Define RISCV_DMEM_ARB_RR_EN for round-robin; default is fixed priority with M1 starvation guard.
module riscv_dmem_arbiter
  import riscv_dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_m0_req,
  input  logic            i_m0_we,
  input  logic            i_m0_lock,
  input  logic [XLEN-1:0] i_m0_addr,
  input  logic [3:0]      i_m0_byte_sel,
  input  logic [XLEN-1:0] i_m0_wr_data,
  input  logic            i_m1_req,
  input  logic            i_m1_we,
  input  logic            i_m1_lock,
  input  logic [XLEN-1:0] i_m1_addr,
  input  logic [3:0]      i_m1_byte_sel,
  input  logic [XLEN-1:0] i_m1_wr_data,
  output logic            o_m0_gnt,
  output logic            o_m1_gnt,
  output logic            o_m0_rvalid,
  output logic            o_m1_rvalid,
  output logic [XLEN-1:0] o_m0_rd_data,
  output logic [XLEN-1:0] o_m1_rd_data,
  output logic [XLEN-1:0] o_mem_addr,
  output logic            o_mem_wr_en,
  output logic [3:0]      o_mem_byte_sel,
  output logic [XLEN-1:0] o_mem_wr_data,
  input  logic [XLEN-1:0] i_mem_rd_data
);

  arb_state_e      r_state;
  logic            w_sel_m0;
  logic            w_sel_m1;
  logic            w_gnt_m0;
  logic            w_gnt_m1;
  logic            w_prefer_m1;
  logic            r_m0_rvalid;
  logic            r_m1_rvalid;
  logic [XLEN-1:0] r_m0_rd_data;
  logic [XLEN-1:0] r_m1_rd_data;

`ifdef RISCV_DMEM_ARB_RR_EN
  logic r_rr_ptr;

  assign w_prefer_m1 = (r_rr_ptr == MST_M1);

  // Pointer names the master that wins the next IDLE tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr <= MST_M0;
    end else if ((r_state == ARB_IDLE) && (w_gnt_m0 || w_gnt_m1)) begin
      r_rr_ptr <= w_gnt_m0 ? MST_M1 : MST_M0;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] r_starve;

  assign w_prefer_m1 = (r_starve == STARVE_LIM);

  // Counts consecutive IDLE denials of M1; held (not bumped) while M0 owns a lock.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve <= 4'd0;
    end else if (!i_m1_req || w_gnt_m1) begin
      r_starve <= 4'd0;
    end else if ((r_state == ARB_IDLE) && (r_starve != STARVE_LIM)) begin
      r_starve <= r_starve + 4'd1;
    end else begin
      r_starve <= r_starve;
    end
  end
`endif

  riscv_arb_sel u_sel (
    .i_m0_req    (i_m0_req),
    .i_m1_req    (i_m1_req),
    .i_state     (r_state),
    .i_prefer_m1 (w_prefer_m1),
    .o_sel_m0    (w_sel_m0),
    .o_sel_m1    (w_sel_m1)
  );

  assign w_gnt_m0 = w_sel_m0 & ~i_rst;
  assign w_gnt_m1 = w_sel_m1 & ~i_rst;
  assign o_m0_gnt = w_gnt_m0;
  assign o_m1_gnt = w_gnt_m1;

  // Memory-side mux; everything idles at zero when nobody is granted.
  always_comb begin
    o_mem_addr     = {XLEN{1'b0}};
    o_mem_wr_en    = 1'b0;
    o_mem_byte_sel = 4'h0;
    o_mem_wr_data  = {XLEN{1'b0}};
    if (w_gnt_m0) begin
      o_mem_addr     = i_m0_addr;
      o_mem_wr_en    = i_m0_we;
      o_mem_byte_sel = mem_byte_sel(i_m0_we, i_m0_byte_sel);
      o_mem_wr_data  = i_m0_wr_data;
    end else if (w_gnt_m1) begin
      o_mem_addr     = i_m1_addr;
      o_mem_wr_en    = i_m1_we;
      o_mem_byte_sel = mem_byte_sel(i_m1_we, i_m1_byte_sel);
      o_mem_wr_data  = i_m1_wr_data;
    end else begin
      o_mem_addr     = {XLEN{1'b0}};
      o_mem_wr_en    = 1'b0;
      o_mem_byte_sel = 4'h0;
      o_mem_wr_data  = {XLEN{1'b0}};
    end
  end

  // Ownership: a locked grant keeps the bus; unlocked grant or dropped req releases it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ARB_IDLE;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_gnt_m0 && i_m0_lock) begin
            r_state <= ARB_LOCK_M0;
          end else if (w_gnt_m1 && i_m1_lock) begin
            r_state <= ARB_LOCK_M1;
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_LOCK_M0: begin
          if (!i_m0_req || !i_m0_lock) begin
            r_state <= ARB_IDLE;
          end else begin
            r_state <= ARB_LOCK_M0;
          end
        end
        ARB_LOCK_M1: begin
          if (!i_m1_req || !i_m1_lock) begin
            r_state <= ARB_IDLE;
          end else begin
            r_state <= ARB_LOCK_M1;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Read return: one-cycle rvalid pulse, data held until that master's next read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_m0_rvalid  <= 1'b0;
      r_m1_rvalid  <= 1'b0;
      r_m0_rd_data <= {XLEN{1'b0}};
      r_m1_rd_data <= {XLEN{1'b0}};
    end else begin
      r_m0_rvalid <= w_gnt_m0 & ~i_m0_we;
      r_m1_rvalid <= w_gnt_m1 & ~i_m1_we;
      if (w_gnt_m0 && !i_m0_we) begin
        r_m0_rd_data <= i_mem_rd_data;
      end else begin
        r_m0_rd_data <= r_m0_rd_data;
      end
      if (w_gnt_m1 && !i_m1_we) begin
        r_m1_rd_data <= i_mem_rd_data;
      end else begin
        r_m1_rd_data <= r_m1_rd_data;
      end
    end
  end

  assign o_m0_rvalid  = r_m0_rvalid;
  assign o_m1_rvalid  = r_m1_rvalid;
  assign o_m0_rd_data = r_m0_rd_data;
  assign o_m1_rd_data = r_m1_rd_data;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Bench for riscv_dmem_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against an ownership/queue-level model.
module tb_riscv_dmem_arbiter;
  import riscv_dmem_arbiter_pkg::*;

  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic rst;
  logic m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
  logic [3:0]  m0_bs, m1_bs;
  logic g0, g1, rv0, rv1, mem_we;
  logic [31:0] rd0, rd1, mem_addr, mem_wd, mem_rd;
  logic [3:0]  mem_bs;

  logic [31:0] dmem    [16];
  logic [31:0] ref_mem [16];

  int n_checks = 0;
  int n_errors = 0;

  // model state: who owns the bus (0 none, 1 M0, 2 M1), M1 denial run, RR turn
  int owner = 0;
  int wait_cnt = 0;
  bit turn = 1'b0;
  bit exp_rv0 = 1'b0, exp_rv1 = 1'b0;
  logic [31:0] exp_rd0 = 32'h0, exp_rd1 = 32'h0;
  bit last_g0 = 1'b0, last_g1 = 1'b0;

  always #5 clk = ~clk;

  riscv_dmem_arbiter #(.STARVE_MAX(STARVE)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_lock(m0_lock), .i_m0_addr(m0_addr),
    .i_m0_byte_sel(m0_bs), .i_m0_wr_data(m0_wd),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_lock(m1_lock), .i_m1_addr(m1_addr),
    .i_m1_byte_sel(m1_bs), .i_m1_wr_data(m1_wd),
    .o_m0_gnt(g0), .o_m1_gnt(g1), .o_m0_rvalid(rv0), .o_m1_rvalid(rv1),
    .o_m0_rd_data(rd0), .o_m1_rd_data(rd1),
    .o_mem_addr(mem_addr), .o_mem_wr_en(mem_we), .o_mem_byte_sel(mem_bs),
    .o_mem_wr_data(mem_wd), .i_mem_rd_data(mem_rd)
  );

  // physical memory behind the arbiter
  assign mem_rd = dmem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_bs[b]) dmem[mem_addr[5:2]][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Decide the expected winner from the rules, compare all outputs, advance the model.
  task automatic model_step();
    bit e0, e1, ewe;
    logic [31:0] ea, ewd;
    logic [3:0] ebs;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst) begin
      if (owner == 1) e0 = m0_req;
      else if (owner == 2) e1 = m1_req;
      else if (m0_req && m1_req) begin
`ifdef RISCV_DMEM_ARB_RR_EN
        if (turn) e1 = 1'b1; else e0 = 1'b1;
`else
        if (wait_cnt >= STARVE) e1 = 1'b1; else e0 = 1'b1;
`endif
      end else begin
        e0 = m0_req;
        e1 = m1_req;
      end
    end
    ea = 32'h0; ewd = 32'h0; ewe = 1'b0; ebs = 4'h0;
    if (e0) begin
      ea = m0_addr; ewe = m0_we; ebs = m0_we ? m0_bs : 4'hF; ewd = m0_wd;
    end else if (e1) begin
      ea = m1_addr; ewe = m1_we; ebs = m1_we ? m1_bs : 4'hF; ewd = m1_wd;
    end
    chk("m0_gnt", 32'(g0), 32'(e0));
    chk("m1_gnt", 32'(g1), 32'(e1));
    chk("mem_wr_en", 32'(mem_we), 32'(ewe));
    chk("mem_addr", mem_addr, ea);
    chk("mem_byte_sel", 32'(mem_bs), 32'(ebs));
    chk("mem_wr_data", mem_wd, ewd);
    chk("m0_rvalid", 32'(rv0), 32'(exp_rv0));
    chk("m1_rvalid", 32'(rv1), 32'(exp_rv1));
    chk("m0_rd_data", rd0, exp_rd0);
    chk("m1_rd_data", rd1, exp_rd1);

    last_g0 = e0;
    last_g1 = e1;
    if (rst) begin
      owner = 0; wait_cnt = 0; turn = 1'b0;
      exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rd0 = 32'h0; exp_rd1 = 32'h0;
    end else begin
      exp_rv0 = e0 && !m0_we;
      exp_rv1 = e1 && !m1_we;
      if (exp_rv0) exp_rd0 = ref_mem[m0_addr[5:2]];
      if (exp_rv1) exp_rd1 = ref_mem[m1_addr[5:2]];
      if (ewe) begin
        for (int b = 0; b < 4; b++) begin
          if (ebs[b]) ref_mem[ea[5:2]][8*b +: 8] = ewd[8*b +: 8];
        end
      end
      if (!m1_req || e1) wait_cnt = 0;
      else if (owner == 0 && wait_cnt < STARVE) wait_cnt++;
      if (owner == 0 && (e0 || e1)) turn = e0;
      if (owner == 0) begin
        if (e0 && m0_lock) owner = 1;
        else if (e1 && m1_lock) owner = 2;
      end else if (owner == 1) begin
        if (!(m0_req && m0_lock)) owner = 0;
      end else begin
        if (!(m1_req && m1_lock)) owner = 0;
      end
    end
  endtask

  task automatic tick();
    #1;
    model_step();
    @(negedge clk);
  endtask

  task automatic set_m0(input logic req, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wd);
    m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wd = wd; m0_bs = 4'hF;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wd);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wd = wd; m1_bs = 4'hF;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      dmem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst = 1'b1;
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // reset with both masters pushing writes
    set_m0(1'b1, 1'b1, 1'b0, 32'h100, 32'hA5A5A5A5);
    set_m1(1'b1, 1'b1, 1'b0, 32'h104, 32'h5A5A5A5A);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rst_m0_gnt", 32'(g0), 32'h0);
      chk("rst_m1_gnt", 32'(g1), 32'h0);
      chk("rst_wr_en", 32'(mem_we), 32'h0);
      tick();
    end
    rst = 1'b0;
    #1;
    chk("release_m0_gnt", 32'(g0), 32'h1);
    chk("release_m1_gnt", 32'(g1), 32'h0);
    tick();
    m0_req = 1'b0;
    tick();
    m1_req = 1'b0;
    tick();

    // M0 write and M1 read of the same word in one cycle
    set_m0(1'b1, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
    set_m1(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
`ifndef RISCV_DMEM_ARB_RR_EN
    #1;
    chk("wr_rd_m0_gnt", 32'(g0), 32'h1);
    chk("wr_rd_m1_wait", 32'(g1), 32'h0);
`endif
    tick();
    m0_req = 1'b0;
`ifndef RISCV_DMEM_ARB_RR_EN
    #1;
    chk("wr_rd_m1_gnt", 32'(g1), 32'h1);
`endif
    tick();
    m1_req = 1'b0;
`ifndef RISCV_DMEM_ARB_RR_EN
    #1;
    chk("wr_rd_rvalid", 32'(rv1), 32'h1);
    chk("wr_rd_data", rd1, 32'hDEADBEEF);
`endif
    tick();

    // starvation: M1 forced in on the fifth contended cycle, counter restarts
    set_m0(1'b1, 1'b0, 1'b0, 32'h120, 32'h0);
    set_m1(1'b1, 1'b0, 1'b0, 32'h124, 32'h0);
    for (int k = 0; k < 6; k++) begin
`ifndef RISCV_DMEM_ARB_RR_EN
      #1;
      chk("starve_m1_gnt", 32'(g1), (k == 4) ? 32'h1 : 32'h0);
`endif
      tick();
    end
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // M1 locked burst blocks M0 until the unlocked write
    set_m1(1'b1, 1'b1, 1'b1, 32'h110, 32'h11111111);
    #1;
    chk("burst_m1_first", 32'(g1), 32'h1);
    tick();
    set_m0(1'b1, 1'b0, 1'b0, 32'h110, 32'h0);
    for (int k = 0; k < 3; k++) begin
      set_m1(1'b1, 1'b1, (k < 2) ? 1'b1 : 1'b0, 32'h114 + 32'(k) * 32'h4, 32'h22220000 + 32'(k));
      #1;
      chk("burst_m0_blocked", 32'(g0), 32'h0);
      chk("burst_m1_gnt", 32'(g1), 32'h1);
      tick();
    end
    m1_req = 1'b0;
    #1;
    chk("burst_m0_after", 32'(g0), 32'h1);
    tick();
    m0_req = 1'b0;
    tick();

    // reset while M1 holds a lock
    set_m1(1'b1, 1'b0, 1'b1, 32'h110, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    chk("lockrst_m1_gnt", 32'(g1), 32'h0);
    tick();
    rst = 1'b0;
    set_m0(1'b1, 1'b0, 1'b0, 32'h114, 32'h0);
    #1;
    chk("lockrst_m0_gnt", 32'(g0), 32'h1);
    chk("lockrst_m1_gnt2", 32'(g1), 32'h0);
    chk("lockrst_no_rvalid", 32'(rv1), 32'h0);
    tick();
    m0_req = 1'b0;
    tick();
    m1_req = 1'b0;
    tick();

    // randomized traffic; pending requests are held until the model grants them
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      if (!(m0_req && !last_g0)) begin
        m0_req  = ($urandom_range(0, 9) < 8);
        m0_we   = 1'($urandom_range(0, 1));
        m0_lock = ($urandom_range(0, 3) == 0);
        m0_addr = 32'h100 + 32'($urandom_range(0, 15)) * 32'h4;
        m0_bs   = 4'($urandom_range(1, 15));
        m0_wd   = $urandom;
      end
      if (!(m1_req && !last_g1)) begin
        m1_req  = ($urandom_range(0, 1) == 1);
        m1_we   = 1'($urandom_range(0, 1));
        m1_lock = ($urandom_range(0, 3) == 0);
        m1_addr = 32'h100 + 32'($urandom_range(0, 15)) * 32'h4;
        m1_bs   = 4'($urandom_range(1, 15));
        m1_wd   = $urandom;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
